// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment page controller.
//   SEG_LUT     hex nibble -> segments {g,f,e,d,c,b,a}, active high
//   NPAGE_DEF   default number of display sources
//   state_e     page FSM states (RUN, HOLD)
//   blank_mask  32-bit word -> per-digit leading-zero blank mask
package seg_pkg;

  localparam int NPAGE_DEF = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Bit i is set when nibbles 7..i are all zero. Digit 0 always shows,
  // so a zero word still displays a single '0'.
  function automatic logic [7:0] blank_mask(input logic [31:0] w);
    logic [7:0] m;
    logic       z;
    m = 8'h00;
    z = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      z    = z & (w[4*i +: 4] == 4'h0);
      m[i] = z;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stability-window debouncer and
// press detector for one active-low button.
//   clk, rst   clock, synchronous active-high reset
//   key_i      raw asynchronous button level (0 = pressed)
//   press_o    one-cycle pulse on an accepted 1->0 transition
module key_debounce #(
  parameter int DEB_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          s, diff, flip;

  assign s    = sync_q[1];
  assign diff = (s != lvl_q);
  // The level flips on the DEB_CYC-th consecutive differing cycle.
  assign flip = diff && (cnt_q == CW'(DEB_CYC - 1));

  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (diff) cnt_d = flip ? '0 : cnt_q + 1'b1;
    if (flip) begin
      lvl_d   = s;
      press_d = ~s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/seg_page_ctrl.sv
// seg_page_ctrl: selects one of NPAGE 32-bit sources for the 8-digit
// display and hands the serializer a frame-aligned snapshot.
//   clk, rst    clock, synchronous active-high reset
//   key0, key1  raw active-low buttons: next page / toggle hold
//   page_data   NPAGE packed 32-bit source words
//   page_vld    per-source valid level
//   frame_done  end-of-scan pulse from the serializer
//   disp_word   snapshot word, disp_blank per-digit blank mask
//   page        current page index, hold = display frozen
module seg_page_ctrl
  import seg_pkg::*;
#(
  parameter int NPAGE    = NPAGE_DEF,
  parameter int DEB_CYC  = 500_000,
  parameter int AUTO_CYC = 0,
  parameter int LZB      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key0,
  input  logic                      key1,
  input  logic [NPAGE-1:0][31:0]    page_data,
  input  logic [NPAGE-1:0]          page_vld,
  input  logic                      frame_done,
  output logic [31:0]               disp_word,
  output logic [7:0]                disp_blank,
  output logic [$clog2(NPAGE)-1:0]  page,
  output logic                      hold
);

  localparam int PW  = $clog2(NPAGE);
  localparam int ACW = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
  localparam int ATC = (AUTO_CYC > 0) ? AUTO_CYC - 1 : 0;

  logic           press0, press1;
  state_e         state_q, state_d;
  logic [PW-1:0]  page_q, page_d;
  logic [ACW-1:0] acnt_q, acnt_d;
  logic           pend_q, pend_d;
  logic [31:0]    word_q, word_d;
  logic [7:0]     blank_q, blank_d;
  logic           auto_en, auto_tick, step, load;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key0 (
    .clk(clk), .rst(rst), .key_i(key0), .press_o(press0)
  );
  key_debounce #(.DEB_CYC(DEB_CYC)) u_key1 (
    .clk(clk), .rst(rst), .key_i(key1), .press_o(press1)
  );

  always_comb begin
    state_d = state_q;
    if (press1) state_d = (state_q == RUN) ? HOLD : RUN;

    auto_en   = (AUTO_CYC != 0) && (state_q == RUN);
    auto_tick = auto_en && (acnt_q == ACW'(ATC));

    acnt_d = acnt_q;
    if (press0)       acnt_d = '0;
    else if (auto_en) acnt_d = auto_tick ? '0 : acnt_q + 1'b1;

    // A coincident press and tick advance only once.
    step   = press0 | auto_tick;
    page_d = page_q;
    if (step) page_d = (page_q == PW'(NPAGE - 1)) ? '0 : page_q + 1'b1;

    // The load uses the current page; a coincident page change keeps
    // pending set so the new page is shown on the next frame.
    load   = frame_done && ((state_q == RUN) || pend_q);
    pend_d = pend_q;
    if (step)      pend_d = 1'b1;
    else if (load) pend_d = 1'b0;

    word_d  = word_q;
    blank_d = blank_q;
    if (load) begin
      word_d = page_data[page_q];
      if (!page_vld[page_q]) blank_d = 8'hFF;
      else if (LZB != 0)     blank_d = blank_mask(page_data[page_q]);
      else                   blank_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      page_q  <= '0;
      acnt_q  <= '0;
      pend_q  <= 1'b1;
      word_q  <= 32'h0;
      blank_q <= 8'hFE;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      acnt_q  <= acnt_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      blank_q <= blank_d;
    end
  end

  assign disp_word  = word_q;
  assign disp_blank = blank_q;
  assign page       = page_q;
  assign hold       = (state_q == HOLD);

endmodule

// File: tb/tb_seg_page_ctrl.sv
module tb_seg_page_ctrl;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            key0 = 1'b1, key1 = 1'b1, frame_done = 1'b0;
  logic [3:0][31:0] pd;
  logic [3:0]       pv;
  logic [31:0]      disp_word;
  logic [7:0]       disp_blank;
  logic [1:0]       page;
  logic             hold;

  // Second instance exercises auto-rotate on its own reset.
  logic            rst_b = 1'b1, key0_b = 1'b1;
  logic [3:0][31:0] pd_b;
  logic [3:0]       pv_b;
  logic [31:0]      disp_word_b;
  logic [7:0]       disp_blank_b;
  logic [1:0]       page_b;
  logic             hold_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_page_ctrl #(.NPAGE(4), .DEB_CYC(4), .AUTO_CYC(0), .LZB(1)) u_dut (
    .clk(clk), .rst(rst), .key0(key0), .key1(key1),
    .page_data(pd), .page_vld(pv), .frame_done(frame_done),
    .disp_word(disp_word), .disp_blank(disp_blank), .page(page), .hold(hold)
  );

  seg_page_ctrl #(.NPAGE(4), .DEB_CYC(4), .AUTO_CYC(10), .LZB(1)) u_auto (
    .clk(clk), .rst(rst_b), .key0(key0_b), .key1(1'b1),
    .page_data(pd_b), .page_vld(pv_b), .frame_done(1'b0),
    .disp_word(disp_word_b), .disp_blank(disp_blank_b), .page(page_b), .hold(hold_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic press0();
    key0 = 1'b0; tick(10);
    key0 = 1'b1; tick(10);
  endtask

  task automatic press1();
    key1 = 1'b0; tick(10);
    key1 = 1'b1; tick(10);
  endtask

  initial begin
    pd = '0; pv = 4'hF; pd_b = '0; pv_b = 4'hF;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_page", 32'(page), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_word", disp_word, 32'h0);
    chk("rst_blank", 32'(disp_blank), 32'hFE);

    pd[0] = 32'h0000_1234;
    frame();
    chk("first_word", disp_word, 32'h0000_1234);
    chk("first_blank", 32'(disp_blank), 32'hF0);
    chk("first_page", 32'(page), 32'd0);

    // Bouncy key: short low bursts must not be accepted.
    key0 = 1'b0; tick(3);
    key0 = 1'b1; tick(1);
    key0 = 1'b0; tick(1);
    key0 = 1'b1; tick(8);
    chk("bounce_no_press", 32'(page), 32'd0);
    key0 = 1'b0; tick(10);
    key0 = 1'b1; tick(10);
    chk("press_page1", 32'(page), 32'd1);
    press0(); chk("press_page2", 32'(page), 32'd2);
    press0(); chk("press_page3", 32'(page), 32'd3);
    press0(); chk("press_wrap0", 32'(page), 32'd0);
    press0(); press0();
    chk("page2", 32'(page), 32'd2);

    // RUN: display follows every frame.
    pd[2] = 32'h0ABC_0001; frame();
    chk("run_w1", disp_word, 32'h0ABC_0001);
    chk("run_b1", 32'(disp_blank), 32'h80);
    pd[2] = 32'h0; frame();
    chk("run_zero_blank", 32'(disp_blank), 32'hFE);
    pd[2] = 32'h1234_5678; frame();
    chk("run_w3", disp_word, 32'h1234_5678);
    chk("run_b3", 32'(disp_blank), 32'h00);

    // HOLD freezes the display.
    press1();
    chk("hold_on", 32'(hold), 32'd1);
    pd[2] = 32'hDEAD_BEEF; frame();
    chk("hold_frozen", disp_word, 32'h1234_5678);

    // Page change while held shows the new page once.
    pd[3] = 32'h0000_00FF;
    press0();
    chk("hold_page3", 32'(page), 32'd3);
    frame();
    chk("hold_new_word", disp_word, 32'h0000_00FF);
    chk("hold_new_blank", 32'(disp_blank), 32'hFC);
    pd[3] = 32'h0000_0011; frame();
    chk("hold_refrozen", disp_word, 32'h0000_00FF);

    press1();
    chk("hold_off", 32'(hold), 32'd0);
    pv[3] = 1'b0; frame();
    chk("invalid_word", disp_word, 32'h0000_0011);
    chk("invalid_blank", 32'(disp_blank), 32'hFF);
    pv[3] = 1'b1;

    // Press pulse lands on the frame_done edge: old page loaded.
    pd[0] = 32'h0000_1234;
    key0 = 1'b0; tick(6);
    frame();
    chk("coinc_page", 32'(page), 32'd0);
    chk("coinc_old_word", disp_word, 32'h0000_0011);
    chk("coinc_old_blank", 32'(disp_blank), 32'hFC);
    key0 = 1'b1; tick(10);
    frame();
    chk("coinc_next_word", disp_word, 32'h0000_1234);

    // Reset coincident with frame_done and a key press.
    press0();
    press1();
    chk("pre_rst_page", 32'(page), 32'd1);
    chk("pre_rst_hold", 32'(hold), 32'd1);
    key0 = 1'b0; tick(6);
    rst = 1'b1; frame_done = 1'b1;
    tick(1);
    rst = 1'b0; frame_done = 1'b0; key0 = 1'b1;
    chk("mrst_page", 32'(page), 32'd0);
    chk("mrst_hold", 32'(hold), 32'd0);
    chk("mrst_word", disp_word, 32'h0);
    chk("mrst_blank", 32'(disp_blank), 32'hFE);
    tick(10);
    chk("mrst_no_late_press", 32'(page), 32'd0);

    // Auto-rotate every 10 cycles.
    rst_b = 1'b0;
    tick(9);
    chk("auto_before", 32'(page_b), 32'd0);
    tick(1);
    chk("auto_tick1", 32'(page_b), 32'd1);
    tick(10);
    chk("auto_tick2", 32'(page_b), 32'd2);
    // Press pulse sampled on the same edge as the third tick.
    tick(3);
    key0_b = 1'b0;
    tick(7);
    chk("auto_coinc_single", 32'(page_b), 32'd3);
    key0_b = 1'b1;
    tick(9);
    chk("auto_cnt_cleared", 32'(page_b), 32'd3);
    tick(1);
    chk("auto_wrap", 32'(page_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg_page_ctrl.md
# seg_page_ctrl

Page controller for the 8-digit serial seven-segment display. It arbitrates between NPAGE 32-bit measurement sources (frequency, duty, timers) and selects one for display using debounced front-panel keys or an optional auto-rotate timer. It hands a frame-aligned, tear-free snapshot plus a leading-zero blank mask to the shift-register display serializer.

## Interface
- NPAGE, 4: number of display sources, 2..8.
- DEB_CYC, 500_000: debounce stability window in clk cycles (10 ms at 50 MHz).
- AUTO_CYC, 0: auto-rotate period in clk cycles; 0 disables auto-rotate.
- LZB, 1: 1 enables leading-zero blanking; 0 forces the blank mask to 0.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key0  in  1  raw async button, active-low; steps to the next page.
- key1  in  1  raw async button, active-low; toggles hold.
- page_data  in  NPAGE×32  packed source words, 8 hex nibbles each; nibble 7 is the leftmost digit.
- page_vld  in  NPAGE  level, per source: word currently meaningful.
- frame_done  in  1  one-cycle pulse from the serializer at the end of each 8-digit scan.
- disp_word  out  32  snapshot to display.
- disp_blank  out  8  per-digit blank, bit i = digit i.
- page  out  $clog2(NPAGE)  current page index.
- hold  out  1  1 = display frozen.

## Operation
- Keys:
  - Each key goes through a 2-FF synchronizer (reset value 1) into a debouncer.
  - The accepted level changes only after DEB_CYC consecutive cycles in which the synchronized level differs from it.
  - An accepted 1→0 transition emits a one-cycle press pulse.
  - Release generates no event.
- Page selection:
  - A key0 press, or an auto tick, sets page to page+1, wrapping from NPAGE-1 to 0.
  - A key0 press clears the auto counter.
  - A key0 press and an auto tick in the same cycle advance the page once only.
- Auto-rotate:
  - Active when AUTO_CYC≠0 and the state is RUN.
  - The counter runs 0..AUTO_CYC-1; the tick fires on the terminal count and the counter returns to 0.
  - The counter is frozen in HOLD.
- FSM states are RUN and HOLD. A key1 press toggles between them; hold = (state==HOLD).
- pending flag:
  - Set on any page change.
  - Cleared on load.
- Load condition, evaluated on frame_done:
  - RUN: load every frame_done.
  - HOLD: load only if pending. A page change while held shows the new page once, then freezes.
- Load action:
  - disp_word ← page_data[page].
  - If page_vld[page]=0, disp_blank ← 8'hFF.
  - Otherwise, with LZB=1, bit i of disp_blank is set iff nibbles 7..i are all zero. Bit 0 is never set.
  - With LZB=0, disp_blank ← 8'h00.
- Reset values:
  - page=0, state RUN, hold=0, auto counter 0, pending=1.
  - disp_word=0, disp_blank=8'hFE.
  - Debounced levels=1 (released).
- Reset mid-operation: rst has priority over every event, including a coincident frame_done or key press; all state returns to reset values.

## Timing
- Press accepted DEB_CYC+2 cycles after the raw key settles low. page/hold update on the following clk edge (registered).
- disp_word/disp_blank update on the edge that samples frame_done, so they are valid in the cycle after the pulse.
- Page change and frame_done in the same cycle: the load uses the old page. pending is set, so the new page loads at the next frame_done, including in HOLD.
- Outputs are constant between frame_done pulses; the serializer never sees a mid-frame change.
- page_data/page_vld are sampled only in the load cycle; there is no other requirement on them.

## Structure
- Package seg_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the NPAGE default;
  - the FSM state enum (RUN, HOLD);
  - the blank-mask function (32-bit word → 8-bit mask).
- Sub-module key_debounce (synchronizer, counter, press pulse), parameterized by DEB_CYC, instantiated twice.
- Top level holds the page/auto counters, FSM, pending flag and snapshot registers.

## Test plan
- Reset then frame_done with page_data[0]=32'h0000_1234, vld=1 → page=0, disp_word=32'h0000_1234, disp_blank=8'hF0.
- DEB_CYC=4; key0 low for 3 cycles with bounce, then low for 6 → exactly one press; page 0→1. Four presses with NPAGE=4 → wraps to 0.
- RUN, page 2 word changes every frame → disp_word follows each frame_done. key1 press → HOLD, disp_word frozen. key0 press in HOLD → next frame_done shows page 3 once, then freezes.
- AUTO_CYC=10, no keys → page increments every 10 cycles. key0 press on the tick cycle → single increment, counter 0.
- page_vld[page]=0 at load → disp_blank=8'hFF. Word 0 with vld=1 → 8'hFE. frame_done coincident with page change → old page loaded, new page at next frame.
- rst asserted for 1 cycle coincident with frame_done and key press → all outputs at reset values; no load, no page change.
